stopwatch_ctrl: RTL and testbench

Run/pause/lap/clear controller for the cascaded mod-K counter chain (centiseconds, seconds, minutes) on the DE-10 Lite. It synchronizes two raw push-button inputs, generates the chain's base tick from the system clock, and sequences counting through a four-state machine. It drives the chain's enable, a registered clear, a display-freeze flag for lap hold, and an overflow flag.

---
 rtl/stopwatch_ctrl.sv | 118 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear controller: button synchronizers, base-tick
// prescaler, and the four-state sequencer driving the mod-K counter chain.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start_stop,
  input  logic       lap_reset,
  input  logic       all_max,
  output logic       tick_en,
  output logic       cnt_nrst,
  output logic       freeze,
  output logic       ovf,
  output logic [1:0] state
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  state_t        r_state, w_nstate;
  logic [PW-1:0] r_p, w_p_n;
  logic          r_ss_s1, r_ss_s2, r_ss_prev;
  logic          r_lr_s1, r_lr_s2, r_lr_prev;
  logic          r_tick_en, r_cnt_nrst, r_freeze, r_ovf;
  logic          w_ss, w_lr, w_running, w_tick, w_ovf_hit, w_ovf_n;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ss_s1   <= 1'b0;
      r_ss_s2   <= 1'b0;
      r_ss_prev <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_lr_prev <= 1'b0;
    end else begin
      r_ss_s1   <= start_stop;
      r_ss_s2   <= r_ss_s1;
      r_ss_prev <= r_ss_s2;
      r_lr_s1   <= lap_reset;
      r_lr_s2   <= r_lr_s1;
      r_lr_prev <= r_lr_s2;
    end
  end

  assign w_ss      = r_ss_s2 & ~r_ss_prev;
  assign w_lr      = r_lr_s2 & ~r_lr_prev;
  assign w_running = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_tick    = w_running && (r_p == P_LAST);
  assign w_ovf_hit = w_tick && all_max;

  always_comb begin
    w_nstate = r_state;
    w_ovf_n  = r_ovf;
    // A saturating tick outranks any button event in the same cycle.
    if (w_ovf_hit) begin
      w_nstate = ST_PAUSE;
      w_ovf_n  = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (w_ss) w_nstate = ST_RUN;
        ST_RUN:   if (w_ss) w_nstate = ST_PAUSE;
                  else if (w_lr) w_nstate = ST_LAP;
        ST_LAP:   if (w_ss) w_nstate = ST_PAUSE;
                  else if (w_lr) w_nstate = ST_RUN;
        ST_PAUSE: begin
          if (w_ss) begin
            if (!r_ovf) w_nstate = ST_RUN;
          end else if (w_lr) begin
            w_nstate = ST_IDLE;
            w_ovf_n  = 1'b0;
          end
        end
        default:  w_nstate = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_p_n = r_p;
    if (r_state == ST_IDLE)
      w_p_n = '0;
    else if (w_running)
      w_p_n = w_tick ? '0 : r_p + PW'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ST_IDLE;
      r_p        <= '0;
      r_tick_en  <= 1'b0;
      r_freeze   <= 1'b0;
      r_ovf      <= 1'b0;
      r_cnt_nrst <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_p        <= w_p_n;
      r_tick_en  <= w_tick & ~all_max;
      r_freeze   <= (w_nstate == ST_LAP);
      r_ovf      <= w_ovf_n;
      r_cnt_nrst <= !((r_state == ST_PAUSE) && (w_nstate == ST_IDLE));
    end
  end

  assign tick_en  = r_tick_en;
  assign cnt_nrst = r_cnt_nrst;
  assign freeze   = r_freeze;
  assign ovf      = r_ovf;
  assign state    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with TICK_DIV=4, 20 ns clock.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       nrst, start_stop, lap_reset, all_max;
  logic       tick_en, cnt_nrst, freeze, ovf;
  logic [1:0] state;
  int         n_cmp = 0;
  int         n_err = 0;
  int         ticks;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start_stop (start_stop),
    .lap_reset  (lap_reset),
    .all_max    (all_max),
    .tick_en    (tick_en),
    .cnt_nrst   (cnt_nrst),
    .freeze     (freeze),
    .ovf        (ovf),
    .state      (state)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    nrst = 1'b1; start_stop = 1'b0; lap_reset = 1'b0; all_max = 1'b0;

    // Reset
    #13 nrst = 1'b0;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_tick", 32'(tick_en), 0);
    chk("rst_freeze", 32'(freeze), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_cnt_nrst", 32'(cnt_nrst), 0);
    #8 nrst = 1'b1;
    step();
    chk("rel_cnt_nrst", 32'(cnt_nrst), 1);
    chk("rel_state", 32'(state), 0);

    // Run cadence
    start_stop = 1'b1; step(); start_stop = 1'b0;
    step(); chk("ss_lat_e2", 32'(state), 0);
    step(); chk("ss_lat_e3", 32'(state), 1);
    ticks = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("run_tick", 32'(tick_en), (k % 4 == 0) ? 1 : 0);
      ticks += int'(tick_en);
    end
    chk("run_tick_count", 32'(ticks), 10);

    // Pause with p=2, hold, resume
    for (int k = 41; k <= 43; k++) begin
      step(); chk("pre_pause_tick", 32'(tick_en), 0);
    end
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("tick_44", 32'(tick_en), 1);
    step(); chk("tick_45", 32'(tick_en), 0); chk("state_45", 32'(state), 1);
    step(); chk("pause_state", 32'(state), 2); chk("pause_tick", 32'(tick_en), 0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_state", 32'(state), 2);
      chk("hold_tick", 32'(tick_en), 0);
    end
    start_stop = 1'b1; step(); start_stop = 1'b0;
    step(); chk("resume_e2", 32'(state), 2);
    step(); chk("resume_e3", 32'(state), 1); chk("resume_tick0", 32'(tick_en), 0);
    step(); chk("resume_tick1", 32'(tick_en), 0);
    step(); chk("resume_tick2", 32'(tick_en), 1);

    // Lap enter / leave, ticks keep cadence
    for (int i = 1; i <= 8; i++) begin
      if (i == 1 || i == 5) lap_reset = 1'b1;
      step();
      lap_reset = 1'b0;
      chk("lap_tick", 32'(tick_en), (i % 4 == 0) ? 1 : 0);
      chk("lap_state", 32'(state), (i >= 3 && i < 7) ? 3 : 1);
      chk("lap_freeze", 32'(freeze), (i >= 3 && i < 7) ? 1 : 0);
    end

    // Simultaneous events: start_stop wins
    start_stop = 1'b1; lap_reset = 1'b1; step();
    start_stop = 1'b0; lap_reset = 1'b0;
    step(); chk("sim_e2", 32'(state), 1);
    step(); chk("sim_state", 32'(state), 2);
    chk("sim_freeze", 32'(freeze), 0);
    chk("sim_tick", 32'(tick_en), 0);

    // Overflow at the tick point (p=3 held during pause)
    all_max = 1'b1;
    step(); step();
    start_stop = 1'b1; step(); start_stop = 1'b0;
    step(); chk("ovf_e2", 32'(state), 2);
    step(); chk("ovf_run", 32'(state), 1); chk("ovf_pre", 32'(ovf), 0);
    chk("ovf_pre_tick", 32'(tick_en), 0);
    step(); chk("ovf_state", 32'(state), 2); chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_no_tick", 32'(tick_en), 0);
    step(); chk("ovf_no_tick2", 32'(tick_en), 0); chk("ovf_state2", 32'(state), 2);

    start_stop = 1'b1; step(); start_stop = 1'b0;
    step(); step(); chk("ovf_ss_ign", 32'(state), 2); chk("ovf_sticky", 32'(ovf), 1);
    step(); chk("ovf_ss_ign2", 32'(state), 2);

    lap_reset = 1'b1; step(); lap_reset = 1'b0;
    step(); chk("clr_e2_state", 32'(state), 2); chk("clr_e2_cnt", 32'(cnt_nrst), 1);
    step(); chk("clr_state", 32'(state), 0); chk("clr_ovf", 32'(ovf), 0);
    chk("clr_cnt_low", 32'(cnt_nrst), 0);
    step(); chk("clr_cnt_high", 32'(cnt_nrst), 1); chk("clr_idle", 32'(state), 0);

    // Held button from IDLE: one event, first tick 4 cycles after RUN edge
    all_max = 1'b0;
    start_stop = 1'b1;
    step(); step();
    step(); chk("held_run", 32'(state), 1);
    step(); chk("held_t1", 32'(tick_en), 0);
    step(); chk("held_t2", 32'(tick_en), 0);
    step(); chk("held_t3", 32'(tick_en), 0);
    start_stop = 1'b0;
    step(); chk("held_t4", 32'(tick_en), 1); chk("held_state", 32'(state), 1);

    // Asynchronous reset mid-count
    step();
    #5 nrst = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_tick", 32'(tick_en), 0);
    chk("arst_freeze", 32'(freeze), 0);
    chk("arst_ovf", 32'(ovf), 0);
    chk("arst_cnt", 32'(cnt_nrst), 0);
    #20 nrst = 1'b1;
    step(); chk("arst_rel_cnt", 32'(cnt_nrst), 1); chk("arst_rel_state", 32'(state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
